// File: rtl/instruction_fetch_unit.sv
// IF stage of the RV32IM pipeline: owns the fetch PC, talks REQ/READY to
// instruction memory and fills the IF/ID register plus decode field slices.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instruction,
  output logic [31:0] pc_out,
  output logic [31:0] pc_plus4,
  output logic [6:0]  opcode,
  output logic [2:0]  func3,
  output logic [6:0]  func7,
  output logic [4:0]  rd,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FETCH   = 2'd1,
    DISCARD = 2'd2,
    HOLD    = 2'd3
  } state_t;

  state_t      state_reg;
  logic [31:0] fetch_pc_reg;
  logic [31:0] redirect_buf_reg;
  logic [31:0] hold_instr_reg;
  logic [31:0] hold_pc_reg;
  logic        req_reg;
  logic        valid_reg;
  logic [31:0] instr_reg;
  logic [31:0] pc_reg;
  logic [31:0] pc_plus4_reg;

  logic [31:0] redirect_tgt;
  logic [31:0] fetch_pc_inc;

  // Targets are word aligned; the low two bits of the EX result are ignored.
  assign redirect_tgt = redirect_pc & ~32'h0000_0003;
  assign fetch_pc_inc = fetch_pc_reg + 32'd4;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg        <= IDLE;
      fetch_pc_reg     <= RESET_PC;
      redirect_buf_reg <= RESET_PC;
      hold_instr_reg   <= NOP_INSTR;
      hold_pc_reg      <= RESET_PC;
      req_reg          <= 1'b0;
      valid_reg        <= 1'b0;
      instr_reg        <= NOP_INSTR;
      pc_reg           <= 32'd0;
      pc_plus4_reg     <= 32'd4;
    end else begin
      case (state_reg)
        IDLE: begin
          state_reg <= FETCH;
          req_reg   <= 1'b1;
        end

        FETCH: begin
          if (imem_ready) begin
            if (redirect) begin
              fetch_pc_reg <= redirect_tgt;
              valid_reg    <= 1'b0;
              instr_reg    <= NOP_INSTR;
            end else if (stall && valid_reg) begin
              // IF/ID is occupied: park the word until decode frees up.
              hold_instr_reg <= imem_rdata;
              hold_pc_reg    <= fetch_pc_reg;
              fetch_pc_reg   <= fetch_pc_inc;
              req_reg        <= 1'b0;
              state_reg      <= HOLD;
            end else begin
              instr_reg    <= imem_rdata;
              pc_reg       <= fetch_pc_reg;
              pc_plus4_reg <= fetch_pc_inc;
              valid_reg    <= 1'b1;
              fetch_pc_reg <= fetch_pc_inc;
            end
          end else if (redirect) begin
            // The request in flight must complete before the address may move.
            redirect_buf_reg <= redirect_tgt;
            valid_reg        <= 1'b0;
            instr_reg        <= NOP_INSTR;
            state_reg        <= DISCARD;
          end else if (!stall) begin
            valid_reg <= 1'b0;
            instr_reg <= NOP_INSTR;
          end
        end

        DISCARD: begin
          if (imem_ready) begin
            fetch_pc_reg <= redirect ? redirect_tgt : redirect_buf_reg;
            state_reg    <= FETCH;
          end else if (redirect) begin
            redirect_buf_reg <= redirect_tgt;
          end
        end

        HOLD: begin
          if (redirect) begin
            fetch_pc_reg <= redirect_tgt;
            valid_reg    <= 1'b0;
            instr_reg    <= NOP_INSTR;
            req_reg      <= 1'b1;
            state_reg    <= FETCH;
          end else if (!stall) begin
            instr_reg    <= hold_instr_reg;
            pc_reg       <= hold_pc_reg;
            pc_plus4_reg <= hold_pc_reg + 32'd4;
            valid_reg    <= 1'b1;
            req_reg      <= 1'b1;
            state_reg    <= FETCH;
          end
        end

        default: begin
          state_reg <= IDLE;
          req_reg   <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req    = req_reg;
  assign imem_addr   = fetch_pc_reg;
  assign instr_valid = valid_reg;
  assign instruction = instr_reg;
  assign pc_out      = pc_reg;
  assign pc_plus4    = pc_plus4_reg;

  assign opcode = instr_reg[6:0];
  assign rd     = instr_reg[11:7];
  assign func3  = instr_reg[14:12];
  assign rs1    = instr_reg[19:15];
  assign rs2    = instr_reg[24:20];
  assign func7  = instr_reg[31:25];

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit: bench-side memory, a behavioural
// model of the IF/ID contents, a per-cycle compare and literal spot checks.
module tb_instruction_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b0;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic [31:0] instruction;
  logic [31:0] pc_out;
  logic [31:0] pc_plus4;
  logic [6:0]  opcode;
  logic [2:0]  func3;
  logic [6:0]  func7;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;

  int n_cmp = 0;
  int n_bad = 0;
  int n_step = 0;

  instruction_fetch_unit #(.RESET_PC(32'h0), .NOP_INSTR(NOP)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .instruction(instruction), .pc_out(pc_out),
    .pc_plus4(pc_plus4), .opcode(opcode), .func3(func3), .func7(func7),
    .rd(rd), .rs1(rs1), .rs2(rs2)
  );

  always #5 clk = ~clk;

  // Memory contents: word at address a is ADDI x(n%32), x0, n with n = a/4 + 1.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] n;
    n = (a >> 2) + 32'd1;
    return (n << 20) | ((n & 32'h1F) << 7) | 32'h13;
  endfunction

  assign imem_rdata = imem_ready ? mem_word(imem_addr) : 32'hDEAD_BEEF;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: where the fetcher is pointing, whether a dropped
  // response is still owed, a parked word, and what IF/ID must show.
  logic        m_started;
  logic [31:0] m_req_pc;
  logic        m_stale;
  logic [31:0] m_stale_tgt;
  logic        m_parked;
  logic [31:0] m_park_w;
  logic [31:0] m_park_pc;
  logic        m_valid;
  logic [31:0] m_instr;
  logic [31:0] m_pc;
  logic        m_pc_known;
  logic [31:0] m_tgt;

  assign m_tgt = (redirect_pc / 32'd4) * 32'd4;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_started <= 1'b0;  m_req_pc <= 32'h0;
      m_stale <= 1'b0;    m_stale_tgt <= 32'h0;
      m_parked <= 1'b0;   m_park_w <= NOP;  m_park_pc <= 32'h0;
      m_valid <= 1'b0;    m_instr <= NOP;   m_pc <= 32'h0;  m_pc_known <= 1'b1;
    end else if (!m_started) begin
      m_started <= 1'b1;
    end else if (m_parked) begin
      if (redirect) begin
        m_parked <= 1'b0; m_req_pc <= m_tgt;
        m_valid <= 1'b0;  m_instr <= NOP; m_pc_known <= 1'b0;
      end else if (!stall) begin
        m_parked <= 1'b0; m_valid <= 1'b1; m_instr <= m_park_w;
        m_pc <= m_park_pc; m_pc_known <= 1'b1;
      end
    end else if (m_stale) begin
      if (imem_ready) begin
        m_stale <= 1'b0;
        m_req_pc <= redirect ? m_tgt : m_stale_tgt;
      end else if (redirect) begin
        m_stale_tgt <= m_tgt;
      end
    end else if (imem_ready) begin
      if (redirect) begin
        m_req_pc <= m_tgt;
        m_valid <= 1'b0; m_instr <= NOP; m_pc_known <= 1'b0;
      end else if (stall && m_valid) begin
        m_parked <= 1'b1; m_park_w <= mem_word(m_req_pc); m_park_pc <= m_req_pc;
        m_req_pc <= m_req_pc + 32'd4;
      end else begin
        m_valid <= 1'b1; m_instr <= mem_word(m_req_pc);
        m_pc <= m_req_pc; m_pc_known <= 1'b1;
        m_req_pc <= m_req_pc + 32'd4;
      end
    end else if (redirect) begin
      m_stale <= 1'b1; m_stale_tgt <= m_tgt;
      m_valid <= 1'b0; m_instr <= NOP; m_pc_known <= 1'b0;
    end else if (!stall) begin
      m_valid <= 1'b0; m_instr <= NOP; m_pc_known <= 1'b0;
    end
  end

  // Per-cycle compare against the model, away from the active edge.
  always @(negedge clk) begin
    chk("imem_req", {31'd0, imem_req}, {31'd0, rst_n && m_started && !m_parked});
    chk("imem_addr", imem_addr, m_req_pc);
    chk("instr_valid", {31'd0, instr_valid}, {31'd0, m_valid});
    chk("instruction", instruction, m_instr);
    chk("opcode", {25'd0, opcode}, {25'd0, m_instr[6:0]});
    chk("rd", {27'd0, rd}, {27'd0, m_instr[11:7]});
    chk("func3", {29'd0, func3}, {29'd0, m_instr[14:12]});
    chk("rs1", {27'd0, rs1}, {27'd0, m_instr[19:15]});
    chk("rs2", {27'd0, rs2}, {27'd0, m_instr[24:20]});
    chk("func7", {25'd0, func7}, {25'd0, m_instr[31:25]});
    if (m_pc_known) begin
      chk("pc_out", pc_out, m_pc);
      chk("pc_plus4", pc_plus4, m_pc + 32'd4);
    end
  end

  // Apply inputs for the next edge, let it happen, report the result.
  task automatic step(input logic r, input logic s, input logic x, input logic [31:0] t);
    imem_ready = r; stall = s; redirect = x; redirect_pc = t;
    @(posedge clk); #2;
    n_step++;
    $display("step %0d rdy=%b stl=%b rdr=%b tgt=%h -> req=%b addr=%h valid=%b pc=%h instr=%h",
             n_step, r, s, x, t, imem_req, imem_addr, instr_valid, pc_out, instruction);
  endtask

  task automatic lit(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk({"lit_", name}, act, exp);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #2;
    lit("rst_req", {31'd0, imem_req}, 32'd0);
    lit("rst_addr", imem_addr, 32'h0);
    lit("rst_valid", {31'd0, instr_valid}, 32'd0);
    lit("rst_instr", instruction, NOP);
    lit("rst_pc", pc_out, 32'h0);
    lit("rst_pc4", pc_plus4, 32'h4);
    lit("rst_opcode", {25'd0, opcode}, 32'h13);
    rst_n = 1'b1;

    // Straight-line fetch, READY every cycle.
    step(1, 0, 0, 0);
    lit("first_req", {31'd0, imem_req}, 32'd1);
    lit("first_addr", imem_addr, 32'h0);
    lit("first_valid", {31'd0, instr_valid}, 32'd0);
    step(1, 0, 0, 0);
    lit("w0_instr", instruction, 32'h0010_0093);
    lit("w0_pc", pc_out, 32'h0);
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    lit("w2_instr", instruction, 32'h0030_0193);
    lit("w2_rd", {27'd0, rd}, 32'd3);
    lit("w2_pc", pc_out, 32'h8);
    lit("model_pc", m_pc, 32'h8);
    lit("w2_addr", imem_addr, 32'hC);

    // Stall with valid IF/ID while the 0xC word returns.
    step(1, 1, 0, 0);
    lit("hold_req", {31'd0, imem_req}, 32'd0);
    lit("hold_pc", pc_out, 32'h8);
    step(0, 1, 0, 0);
    step(0, 0, 0, 0);
    lit("unhold_pc", pc_out, 32'hC);
    lit("unhold_addr", imem_addr, 32'h10);

    // Slow memory: three wait cycles per request.
    for (int k = 0; k < 2; k++) begin
      step(0, 0, 0, 0);
      lit("wait_instr", instruction, NOP);
      step(0, 0, 0, 0);
      step(0, 0, 0, 0);
      step(1, 0, 0, 0);
    end
    lit("slow_pc", pc_out, 32'h14);
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    lit("pre_rdr_addr", imem_addr, 32'h20);

    // Redirect while 0x20 is outstanding.
    step(0, 0, 1, 32'h103);
    lit("disc_addr", imem_addr, 32'h20);
    step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    lit("rdr_addr", imem_addr, 32'h100);
    lit("rdr_valid", {31'd0, instr_valid}, 32'd0);
    step(1, 0, 0, 0);
    lit("rdr_instr", instruction, 32'h0410_0093);
    lit("rdr_pc", pc_out, 32'h100);

    // Newest redirect wins while discarding.
    step(0, 0, 1, 32'h200);
    step(0, 0, 1, 32'h300);
    step(1, 0, 0, 0);
    lit("newest_addr", imem_addr, 32'h300);
    step(1, 0, 0, 0);

    // Redirect under stall while holding a parked word.
    step(1, 1, 0, 0);
    step(0, 1, 1, 32'h400);
    lit("hold_rdr_valid", {31'd0, instr_valid}, 32'd0);
    lit("hold_rdr_addr", imem_addr, 32'h400);
    step(1, 0, 0, 0);
    lit("hold_rdr_pc", pc_out, 32'h400);

    // Redirect coinciding with READY, then stall while waiting.
    step(1, 0, 1, 32'h500);
    step(1, 0, 0, 0);
    step(0, 1, 0, 0);
    lit("stall_wait_pc", pc_out, 32'h500);

    // Address wrap at the top of memory.
    step(1, 0, 1, 32'hFFFF_FFF9);
    lit("wrap_tgt", imem_addr, 32'hFFFF_FFF8);
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    lit("wrap_pc", pc_out, 32'hFFFF_FFFC);
    lit("wrap_pc4", pc_plus4, 32'h0);
    lit("wrap_addr", imem_addr, 32'h0);
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);

    // Reset mid-request with READY asserted.
    imem_ready = 1'b1;
    rst_n = 1'b0;
    #1;
    lit("mid_rst_req", {31'd0, imem_req}, 32'd0);
    lit("mid_rst_valid", {31'd0, instr_valid}, 32'd0);
    lit("mid_rst_addr", imem_addr, 32'h0);
    repeat (2) @(posedge clk);
    #2;
    imem_ready = 1'b0;
    rst_n = 1'b1;
    step(1, 0, 0, 0);
    lit("restart_req", {31'd0, imem_req}, 32'd1);
    lit("restart_valid", {31'd0, instr_valid}, 32'd0);
    step(1, 0, 0, 0);
    lit("restart_pc", pc_out, 32'h0);
    lit("restart_instr", instruction, 32'h0010_0093);
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);

    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
